// File: rtl/minutos_if.sv
// Signal bundle between the minutes stage and its surroundings.
// The slave side is the minutes counter; the master side is whatever
// drives ticks/switches/buttons and observes the count and display.
// There is no valid/ready handshake here: tick_in is a one-cycle
// strobe, the switches and buttons are levels sampled every clock, and
// every output is a plain registered value.
interface minutos_if;
    logic       tick_in;
    logic       run_sw;
    logic       set_sw;
    logic       UP;
    logic       DOWN;
    logic       carry_out;
    logic [5:0] minuto;
    logic       armed;      // button edge qualifier, exposed for observation
    logic       a, b, c, d, e, f, g;
    logic       a1, b1, c1, d1, e1, f1, g1;

    modport slave (
        input  tick_in, run_sw, set_sw, UP, DOWN,
        output carry_out, minuto, armed,
        output a, b, c, d, e, f, g,
        output a1, b1, c1, d1, e1, f1, g1
    );

    modport master (
        output tick_in, run_sw, set_sw, UP, DOWN,
        input  carry_out, minuto, armed,
        input  a, b, c, d, e, f, g,
        input  a1, b1, c1, d1, e1, f1, g1
    );
endinterface

// File: rtl/minutos.sv
// Minutes stage of the digital clock: counts 0..MODULO-1 on ticks from
// the seconds stage, pulses carry_out on rollover, can be stepped with
// UP/DOWN in set mode, and drives two registered active-low 7-seg digits.
module minutos #(
    parameter int MODULO = 60,
    parameter int INIT   = 0
) (
    input  logic     clock,
    input  logic     reset_n,
    minutos_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_SET  = 2'd2
    } mode_t;

    // Digit to segments {a,b,c,d,e,f,g}, 0 = lit; anything above 9 is blank.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    localparam logic [5:0] MOD6       = 6'(MODULO);
    localparam logic [5:0] LAST6      = 6'(MODULO - 1);
    localparam logic [5:0] INIT6      = 6'(INIT);
    localparam logic [6:0] SEG_INIT_U = seg7(4'(INIT % 10));
    localparam logic [6:0] SEG_INIT_T = seg7(4'(INIT / 10));

    logic [5:0] r_minuto;
    logic       r_carry;
    logic       r_armed;
    logic [6:0] r_seg_u;
    logic [6:0] r_seg_t;

    mode_t      w_mode;
    logic [5:0] w_minuto_nxt;
    logic       w_carry_nxt;
    logic       w_armed_nxt;
    logic [3:0] w_units;
    logic [3:0] w_tens;

    // Decode the mode switches fresh every cycle; invalid combos mean hold.
    always_comb begin
        w_mode = MODE_HOLD;
        if (bus.run_sw && !bus.set_sw) begin
            w_mode = MODE_RUN;
        end else if (bus.set_sw && !bus.run_sw) begin
            w_mode = MODE_SET;
        end
    end

    // Next count, carry and arming; the out-of-range guard overrides all modes.
    always_comb begin
        w_minuto_nxt = r_minuto;
        w_carry_nxt  = 1'b0;
        w_armed_nxt  = r_armed;

        // Releasing both buttons re-arms stepping, whatever the mode.
        if (!bus.UP && !bus.DOWN) begin
            w_armed_nxt = 1'b1;
        end

        if (r_minuto >= MOD6) begin
            w_minuto_nxt = 6'd0;
        end else begin
            case (w_mode)
                MODE_RUN: begin
                    if (bus.tick_in) begin
                        if (r_minuto == LAST6) begin
                            w_minuto_nxt = 6'd0;
                            w_carry_nxt  = 1'b1;
                        end else begin
                            w_minuto_nxt = r_minuto + 6'd1;
                        end
                    end
                end
                MODE_SET: begin
                    // UP wins when both buttons arrive on the arming cycle.
                    if (r_armed && bus.UP) begin
                        w_minuto_nxt = (r_minuto == LAST6) ? 6'd0 : r_minuto + 6'd1;
                        w_armed_nxt  = 1'b0;
                    end else if (r_armed && bus.DOWN) begin
                        w_minuto_nxt = (r_minuto == 6'd0) ? LAST6 : r_minuto - 6'd1;
                        w_armed_nxt  = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Count, carry and edge-qualifier registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_minuto <= INIT6;
            r_carry  <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_minuto <= w_minuto_nxt;
            r_carry  <= w_carry_nxt;
            r_armed  <= w_armed_nxt;
        end
    end

    assign w_units = 4'(r_minuto % 6'd10);
    assign w_tens  = 4'(r_minuto / 6'd10);

    // Display registers follow the count one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_seg_u <= SEG_INIT_U;
            r_seg_t <= SEG_INIT_T;
        end else begin
            r_seg_u <= seg7(w_units);
            r_seg_t <= seg7(w_tens);
        end
    end

    assign bus.minuto    = r_minuto;
    assign bus.carry_out = r_carry;
    assign bus.armed     = r_armed;
    assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g}        = r_seg_u;
    assign {bus.a1, bus.b1, bus.c1, bus.d1, bus.e1, bus.f1, bus.g1} = r_seg_t;

endmodule

// File: tb/tb_minutos.sv
// Bench for the minutes stage: a vector table for set/hold/run stepping,
// hand-written sequences for rollover, async reset and back-to-back ticks,
// then random traffic against a reference model of the clock rules.
module tb_minutos;

    logic clock;
    logic reset_n;

    minutos_if bus();

    minutos #(.MODULO(60), .INIT(0)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] enc [10];

    // ---------------- reference model ----------------
    int   m_min;
    int   m_seg_src;   // minute value currently on the display
    logic m_carry;
    logic m_armed;
    logic m_in_reset;

    task automatic model_reset();
        m_min     = 0;
        m_seg_src = 0;
        m_carry   = 1'b0;
        m_armed   = 1'b0;
    endtask

    // One rising edge of the clock as the rules describe it.
    task automatic model_edge(input logic t, input logic r, input logic s,
                              input logic u, input logic d);
        bit is_run;
        bit is_set;
        bit stepped;
        if (m_in_reset) return;
        is_run    = r && !s;
        is_set    = s && !r;
        stepped   = 0;
        m_seg_src = m_min;
        m_carry   = 1'b0;
        if (m_min >= 60) begin
            m_min = 0;
        end else if (is_run && t) begin
            m_carry = (m_min == 59);
            m_min   = (m_min + 1) % 60;
        end else if (is_set && m_armed && u) begin
            m_min   = (m_min + 1) % 60;
            stepped = 1;
        end else if (is_set && m_armed && d) begin
            m_min   = (m_min + 59) % 60;
            stepped = 1;
        end
        if (!u && !d)    m_armed = 1'b1;
        else if (stepped) m_armed = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic t, input logic r, input logic s,
                               input logic u, input logic d);
        bus.tick_in = t;
        bus.run_sw  = r;
        bus.set_sw  = s;
        bus.UP      = u;
        bus.DOWN    = d;
        model_edge(t, r, s, u, d);
        @(posedge clock);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    function automatic int seg_u();
        return int'({bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g});
    endfunction

    function automatic int seg_t();
        return int'({bus.a1, bus.b1, bus.c1, bus.d1, bus.e1, bus.f1, bus.g1});
    endfunction

    task automatic compare_model(input string name);
        chk({name, ".minuto"}, int'(bus.minuto), m_min);
        chk({name, ".carry"},  int'(bus.carry_out), int'(m_carry));
        chk({name, ".armed"},  int'(bus.armed), int'(m_armed));
        chk({name, ".units"},  seg_u(), int'(enc[m_seg_src % 10]));
        chk({name, ".tens"},   seg_t(), int'(enc[m_seg_src / 10]));
    endtask

    task automatic apply_reset();
        bus.tick_in = 0; bus.run_sw = 0; bus.set_sw = 0; bus.UP = 0; bus.DOWN = 0;
        reset_n    = 1'b0;
        m_in_reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n    = 1'b1;
        m_in_reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic t, r, s, u, d;
        int   exp_min;
        logic exp_carry;
    } vec_t;

    vec_t vt [24];

    task automatic fill_table();
        //        t  r  s  u  d   min carry
        vt[0]  = '{0, 0, 1, 0, 0,  0, 0};  // arm
        vt[1]  = '{0, 0, 1, 1, 0,  1, 0};  // step up
        vt[2]  = '{0, 0, 1, 1, 0,  1, 0};  // held: no repeat
        vt[3]  = '{0, 0, 1, 1, 0,  1, 0};
        vt[4]  = '{0, 0, 1, 0, 0,  1, 0};  // release
        vt[5]  = '{0, 0, 1, 1, 0,  2, 0};
        vt[6]  = '{0, 0, 1, 0, 0,  2, 0};
        vt[7]  = '{0, 0, 1, 0, 1,  1, 0};  // step down
        vt[8]  = '{0, 0, 1, 0, 0,  1, 0};
        vt[9]  = '{0, 0, 1, 1, 1,  2, 0};  // both: UP wins, single step
        vt[10] = '{0, 0, 1, 0, 0,  2, 0};
        vt[11] = '{1, 0, 1, 0, 0,  2, 0};  // tick ignored in set
        vt[12] = '{1, 1, 1, 0, 0,  2, 0};  // hold (both switches)
        vt[13] = '{1, 0, 0, 0, 0,  2, 0};  // hold (no switch)
        vt[14] = '{1, 1, 0, 0, 0,  3, 0};  // run tick
        vt[15] = '{0, 1, 0, 0, 0,  3, 0};
        vt[16] = '{1, 1, 0, 0, 0,  4, 0};
        vt[17] = '{0, 0, 1, 0, 1,  3, 0};  // back in set, continues from 4
        vt[18] = '{0, 0, 1, 0, 0,  3, 0};
        vt[19] = '{0, 0, 1, 0, 1,  2, 0};
        vt[20] = '{0, 0, 1, 0, 0,  2, 0};
        vt[21] = '{0, 0, 1, 0, 1,  1, 0};
        vt[22] = '{0, 0, 1, 0, 0,  1, 0};
        vt[23] = '{0, 0, 1, 0, 1,  0, 0};
    endtask

    // ---------------- test ----------------
    initial begin
        int carry_seen;
        enc[0] = 7'b0000001; enc[1] = 7'b1001111; enc[2] = 7'b0010010;
        enc[3] = 7'b0000110; enc[4] = 7'b1001100; enc[5] = 7'b0100100;
        enc[6] = 7'b0100000; enc[7] = 7'b0001111; enc[8] = 7'b0000000;
        enc[9] = 7'b0000100;
        m_in_reset = 1'b0;
        reset_n    = 1'b1;
        #2;
        apply_reset();

        // Reset state
        chk("reset.minuto", int'(bus.minuto), 0);
        chk("reset.carry",  int'(bus.carry_out), 0);
        chk("reset.armed",  int'(bus.armed), 0);
        chk("reset.units",  seg_u(), 7'b0000001);
        chk("reset.tens",   seg_t(), 7'b0000001);

        // Table-driven set/hold/run stepping
        fill_table();
        for (int i = 0; i < 24; i++) begin
            drive_cycle(vt[i].t, vt[i].r, vt[i].s, vt[i].u, vt[i].d);
            chk($sformatf("vec%0d.minuto", i), int'(bus.minuto), vt[i].exp_min);
            chk($sformatf("vec%0d.carry", i), int'(bus.carry_out), int'(vt[i].exp_carry));
            compare_model($sformatf("vec%0d", i));
        end
        // 0 -> 59 on DOWN, then 59 -> 0 on UP without carry
        drive_cycle(0, 0, 1, 0, 0);
        drive_cycle(0, 0, 1, 0, 1);
        chk("set.down_wrap", int'(bus.minuto), 59);
        drive_cycle(0, 0, 1, 0, 0);
        drive_cycle(0, 0, 1, 1, 0);
        chk("set.up_wrap", int'(bus.minuto), 0);
        chk("set.up_wrap_carry", int'(bus.carry_out), 0);

        // UP held 20 cycles: one step only
        drive_cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) drive_cycle(0, 0, 1, 1, 0);
        chk("set.held_up", int'(bus.minuto), 1);
        drive_cycle(0, 0, 1, 0, 0);
        drive_cycle(0, 0, 1, 1, 0);
        chk("set.second_press", int'(bus.minuto), 2);

        // Run: 59 ticks spaced 3 cycles apart from 0
        apply_reset();
        carry_seen = 0;
        for (int i = 0; i < 59; i++) begin
            drive_cycle(1, 1, 0, 0, 0);
            if (bus.carry_out) carry_seen++;
            drive_cycle(0, 1, 0, 0, 0);
            drive_cycle(0, 1, 0, 0, 0);
            compare_model("run59");
        end
        chk("run59.minuto", int'(bus.minuto), 59);
        chk("run59.no_carry", carry_seen, 0);
        chk("run59.units", seg_u(), 7'b0000100);
        chk("run59.tens",  seg_t(), 7'b0100100);

        // Rollover 59 -> 0 with a single carry cycle
        drive_cycle(1, 1, 0, 0, 0);
        chk("roll.minuto", int'(bus.minuto), 0);
        chk("roll.carry",  int'(bus.carry_out), 1);
        chk("roll.units_lag", seg_u(), 7'b0000100);
        drive_cycle(0, 1, 0, 0, 0);
        chk("roll.carry_drop", int'(bus.carry_out), 0);
        chk("roll.units", seg_u(), 7'b0000001);
        chk("roll.tens",  seg_t(), 7'b0000001);

        // Async reset mid-count at 37
        for (int i = 0; i < 37; i++) drive_cycle(1, 1, 0, 0, 0);
        drive_cycle(0, 1, 0, 0, 0);
        chk("areset.pre", int'(bus.minuto), 37);
        #3;
        reset_n    = 1'b0;
        m_in_reset = 1'b1;
        model_reset();
        #1;
        chk("areset.minuto", int'(bus.minuto), 0);
        chk("areset.units",  seg_u(), 7'b0000001);
        chk("areset.tens",   seg_t(), 7'b0000001);
        for (int i = 0; i < 4; i++) drive_cycle(1, 1, 0, 0, 0);
        chk("areset.held", int'(bus.minuto), 0);
        reset_n    = 1'b1;
        m_in_reset = 1'b0;
        drive_cycle(1, 1, 0, 0, 0);
        chk("areset.resume", int'(bus.minuto), 1);

        // Back-to-back ticks from 58
        for (int i = 0; i < 57; i++) drive_cycle(1, 1, 0, 0, 0);
        drive_cycle(0, 1, 0, 0, 0);
        chk("b2b.start", int'(bus.minuto), 58);
        carry_seen = 0;
        drive_cycle(1, 1, 0, 0, 0);
        chk("b2b.59", int'(bus.minuto), 59);
        if (bus.carry_out) carry_seen++;
        drive_cycle(1, 1, 0, 0, 0);
        chk("b2b.0", int'(bus.minuto), 0);
        chk("b2b.carry_aligned", int'(bus.carry_out), 1);
        if (bus.carry_out) carry_seen++;
        drive_cycle(0, 1, 0, 0, 0);
        if (bus.carry_out) carry_seen++;
        chk("b2b.carry_once", carry_seen, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic t, r, s, u, d;
            int   mode_pick;
            mode_pick = int'($urandom_range(0, 9));
            r = (mode_pick < 5) || (mode_pick == 9);
            s = (mode_pick >= 5);
            t = ($urandom_range(0, 3) == 0);
            u = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 2) == 0);
            drive_cycle(t, r, s, u, d);
            compare_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/minutos.md
Name: minutos

Overview:
- Minutes stage of the digital clock.
- Counts 0..59 on one-cycle ticks from the seconds stage.
- Emits a one-cycle carry pulse that is consumed directly as the hours stage's increment-enable input.
- Supports manual set via UP/DOWN push-buttons.
- Drives two active-low 7-segment digits (units, tens) with registered outputs.

Parameters:
- MODULO, 60, count range 0..MODULO-1; wrap point for carry.
- INIT, 0, value loaded into the minute register on reset.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick_in  in  1  one-cycle pulse from the seconds stage (seconds 59->0).
- run_sw  in  1  mode switch; 1 = run.
- set_sw  in  1  mode switch; 1 = set minutes.
- UP  in  1  increment button, level, synchronous to clock.
- DOWN  in  1  decrement button, level, synchronous to clock.
- carry_out  out  1  one-cycle pulse on 59->0 rollover in run mode.
- minuto  out  6  current minute value (binary).
- a,b,c,d,e,f,g  out  1 each  units digit segments, active-low.
- a1,b1,c1,d1,e1,f1,g1  out  1 each  tens digit segments, active-low.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - minuto=INIT, carry_out=0, armed=0.
  - Segment outputs show INIT: for INIT=0 both digits show 0, i.e. a..f=0, g=1, a1..f1=0, g1=1.
  - All state is held while reset is low. Deassertion takes effect at the next clock edge.
- Mode is decoded every cycle, no latching:
  - RUN: run_sw=1 and set_sw=0.
  - SET: set_sw=1 and run_sw=0.
  - HOLD: all other combinations. The count is frozen and ticks are dropped.
- RUN:
  - tick_in=1 and minuto<MODULO-1: minuto+1 next edge, carry_out=0.
  - tick_in=1 and minuto=MODULO-1: minuto=0 and carry_out=1 on the same edge.
  - carry_out is high for exactly one cycle, then returns to 0.
  - UP/DOWN are ignored. armed is still updated (see SET).
- SET:
  - tick_in is ignored; carry_out stays 0.
  - Edge qualifier `armed` is set to 1 on any cycle with UP=0 and DOWN=0.
  - UP=1 and armed=1: minuto+1 (59->0, no carry), armed=0.
  - Else DOWN=1 and armed=1: minuto-1 (0->59), armed=0.
  - UP has priority when both are pressed on the arming cycle.
  - A held button produces exactly one step. Both buttons must be released before the next step.
- HOLD: carry_out=0 and minuto unchanged. armed still follows the release rule.
- Out-of-range guard: if minuto>=MODULO in any mode, it is forced to 0 on the next edge, with no carry.
- Arithmetic: all 6-bit, unsigned. No value outside 0..MODULO-1 is ever visible for more than one cycle.
- Segment outputs:
  - Registered from minuto, so the display lags minuto by 1 cycle.
  - units = minuto%10, tens = minuto/10. Tens only ever reaches 0..5.
  - Encoding (a b c d e f g, 0 = lit):
    - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
    - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Mode switch mid-count: no reset of minuto. Switching from SET to RUN continues from the set value. The first tick in RUN counts normally.
- tick_in coincident with the mode changing to SET: the tick is dropped, because the decoded mode at that edge governs.

Test Plan:
- Reset with INIT=0 then release; run mode; 59 tick_in pulses spaced 3 cycles apart -> minuto=59, display tens=0100100, units=0000100, carry_out never high.
- From minuto=59 in run, one tick_in -> minuto=0 on that edge, carry_out=1 for exactly 1 cycle, display shows 00 one cycle later.
- Set mode, minuto=0, UP held 20 cycles then released, pressed again -> minuto 0->1->2; then DOWN from 0 -> 59; UP at 59 -> 0 with carry_out=0.
- Set mode with UP and DOWN asserted together after release -> minuto increments by 1 only. tick_in pulses in set and hold modes -> no change, carry_out=0.
- Assert reset_n low mid-count at minuto=37 between clock edges -> minuto=0 and segments show 00 immediately, without waiting for a clock edge. Stays there while low; counting resumes on ticks after release.
- Back-to-back tick_in on consecutive cycles from 58 -> 59 then 0. carry_out pulses exactly once, aligned with the 0 value.
